// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: multi-cycle unsigned MUL/DIV/MOD unit, one bit per clock.
// Ports: clk, rst (async, active-high); start/op/a/b/rd_in request;
//   busy, done, wrt, result, rd_out, div0 status and write-back.
module seq_muldiv_unit #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   rd_in,
   output logic         busy,
   output logic         done,
   output logic         wrt,
   output logic [W-1:0] result,
   output logic [3:0]   rd_out,
   output logic         div0
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   // Multiplicand for MUL, divisor for DIV/MOD.
   logic [W-1:0]  opnd_q, opnd_d;
   // MUL: {hi,lo} is the product/multiplier shift pair.
   // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [3:0]    rdl_q, rdl_d;
   logic [W-1:0]  res_q, res_d;
   logic [3:0]    rdo_q, rdo_d;
   logic          div0_q, div0_d;

   logic [W:0]    mul_sum;
   logic [W:0]    part;
   logic [W:0]    trial;
   logic          ge;
   logic [W-1:0]  it_hi;
   logic [W-1:0]  it_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rdl_q   <= '0;
         res_q   <= '0;
         rdo_q   <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rdl_q   <= rdl_d;
         res_q   <= res_d;
         rdo_q   <= rdo_d;
         div0_q  <= div0_d;
      end
   end

   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      part    = {hi_q, lo_q[W-1]};
      trial   = part - {1'b0, opnd_q};
      // The remainder stays below the divisor (or below 2^k on the
      // k-th step when dividing by zero), so the trial MSB is the borrow.
      ge      = ~trial[W];
      if (op_q[1]) begin
         it_hi = ge ? trial[W-1:0] : part[W-1:0];
         it_lo = {lo_q[W-2:0], ge};
      end else begin
         it_hi = mul_sum[W:1];
         it_lo = {mul_sum[0], lo_q[W-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rdl_d   = rdl_q;
      res_d   = res_q;
      rdo_d   = rdo_q;
      div0_d  = div0_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               op_d    = op;
               opnd_d  = op[1] ? b : a;
               hi_d    = '0;
               lo_d    = op[1] ? a : b;
               cnt_d   = '0;
               rdl_d   = rd_in;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            hi_d  = it_hi;
            lo_d  = it_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               res_d   = op_q[0] ? it_hi : it_lo;
               rdo_d   = rdl_q;
               div0_d  = op_q[1] & (opnd_q == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign wrt    = done;
   assign result = res_q;
   assign rd_out = rdo_q;
   assign div0   = div0_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: directed plus random checks of seq_muldiv_unit
// against an arithmetic reference model.
module tb_seq_muldiv_unit;

   localparam int W = 8;
   localparam int BOUND = 30;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   rd_in = '0;
   logic         busy;
   logic         done;
   logic         wrt;
   logic [W-1:0] result;
   logic [3:0]   rd_out;
   logic         div0;

   int tests = 0;
   int fails = 0;

   seq_muldiv_unit #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .a(a), .b(b), .rd_in(rd_in), .busy(busy), .done(done),
      .wrt(wrt), .result(result), .rd_out(rd_out), .div0(div0)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_res(input logic [1:0] o,
                                            input int unsigned x,
                                            input int unsigned y);
      int unsigned p;
      int unsigned m;
      m = (1 << W) - 1;
      p = x * y;
      case (o)
         2'd0: return W'(p & m);
         2'd1: return W'(p >> W);
         2'd2: return (y == 0) ? W'(m) : W'(x / y);
         default: return (y == 0) ? W'(x) : W'(x % y);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble operands during RUN, check latency and outputs.
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [3:0] r);
      int n;
      logic [W-1:0] exp;
      exp = ref_res(o, x, y);
      @(negedge clk);
      op = o; a = x; b = y; rd_in = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      op = 2'($urandom);
      chk({tag, ".busy_rise"}, busy, 1'b1);
      n = 0;
      while (done !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, n, W);
      chk({tag, ".busy_in_done"}, busy, 1'b0);
      chk({tag, ".wrt"}, wrt, 1'b1);
      chk({tag, ".result"}, result, exp);
      chk({tag, ".rd_out"}, rd_out, r);
      chk({tag, ".div0"}, div0, (o[1] && y == 0));
      @(negedge clk);
      chk({tag, ".done_pulse"}, {done, wrt}, 2'b00);
      chk({tag, ".result_hold"}, result, exp);
   endtask

   initial begin
      int n;
      int pulses;
      logic [1:0] ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      // Reset with start asserted.
      rst = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset.outs", {busy, done, wrt, result, rd_out, div0}, '0);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("reset.idle", {busy, done}, 2'b00);

      run_op("mul13x11", 2'd0, 8'd13, 8'd11, 4'd5);
      chk("mul13x11.const", result, 8'h8F);
      run_op("mulhi200", 2'd1, 8'd200, 8'd200, 4'd1);
      chk("mulhi200.const", result, 8'h9C);
      run_op("mullo200", 2'd0, 8'd200, 8'd200, 4'd2);
      chk("mullo200.const", result, 8'h40);
      run_op("div200_7", 2'd2, 8'd200, 8'd7, 4'd3);
      chk("div200_7.const", result, 8'h1C);
      run_op("mod200_7", 2'd3, 8'd200, 8'd7, 4'd4);
      chk("mod200_7.const", result, 8'h04);
      run_op("div0q", 2'd2, 8'h5A, 8'd0, 4'd6);
      chk("div0q.const", {div0, result}, 9'h1FF);
      run_op("div0r", 2'd3, 8'h5A, 8'd0, 4'd7);
      chk("div0r.const", {div0, result}, 9'h15A);

      // start held high through RUN, then back-to-back issue from DONE.
      @(negedge clk);
      op = 2'd0; a = 8'd21; b = 8'd19; rd_in = 4'd9; start = 1'b1;
      @(negedge clk);
      n = 0;
      while (done !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk("b2b.first_latency", n, W);
      chk("b2b.first_result", result, ref_res(2'd0, 21, 19));
      op = 2'd3; a = 8'd250; b = 8'd9; rd_in = 4'd10;
      @(negedge clk);
      start = 1'b0;
      chk("b2b.relaunch", {busy, done}, 2'b10);
      n = 1;
      while (done !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk("b2b.done_spacing", n, W + 1);
      chk("b2b.second_result", result, ref_res(2'd3, 250, 9));
      chk("b2b.second_rd", rd_out, 4'd10);
      @(negedge clk);

      // Reset in the middle of an operation.
      op = 2'd1; a = 8'd77; b = 8'd99; rd_in = 4'd12; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst.busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst.outs", {busy, done, wrt, result, rd_out, div0}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1 || wrt === 1'b1) pulses++;
      end
      chk("midrst.no_pulse", pulses, 0);
      run_op("midrst.after", 2'd2, 8'd143, 8'd12, 4'd13);

      // Random operations.
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom);
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         run_op($sformatf("rnd%0d", i), ro, ra, rb, 4'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_muldiv_unit.md
Name: seq_muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide execution unit that sits directly downstream of the 16-entry register file.
- Consumes the two register-file read ports as operands.
- Produces the write-back data, destination index and write strobe that feed the register file write port (din1, Rd, wrt).
- Iterates one bit per clock so the single-cycle datapath can issue MUL/DIV/MOD without a wide combinational array.

Parameters:
- W, 8, operand/result width in bits; must match the register file W. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only in IDLE or DONE
- op  input  2  00 MUL low half, 01 MUL high half, 10 DIV quotient, 11 MOD remainder
- a  input  W  operand A (dividend/multiplicand), from register file dout1
- b  input  W  operand B (divisor/multiplier), from register file dout2
- rd_in  input  4  destination register index for the result
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle completion pulse
- wrt  output  1  register-file write enable; identical to done
- result  output  W  write-back data to register file din1
- rd_out  output  4  destination index to register file Rd
- div0  output  1  divisor was zero on the last completed DIV/MOD

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0; busy, done, wrt, div0 = 0; result = 0; rd_out = 0. Any in-flight operation is discarded and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at a clock edge -> latch a, b, op and rd_in, clear the accumulator, set counter=0, go to RUN. start=0 -> stay in IDLE.
  - RUN: perform one iteration per edge and increment the counter. After the W-th iteration edge, go to DONE. start is ignored; operand inputs may change freely after the latch edge.
  - DONE: done=1 and wrt=1 for exactly this one cycle; result, rd_out and div0 are updated at the edge entering DONE. Next edge: start=1 -> latch new operands and go to RUN (back-to-back issue); start=0 -> go to IDLE.
- Latency: if start is sampled at edge 0, done is high in the cycle following edge W (W=8: after edge 8). Throughput is one operation per W+1 cycles.
- busy=1 exactly while in RUN; busy=0 in IDLE and DONE.
- result, rd_out and div0 hold their values until the next entry into DONE or a reset.
- MUL uses shift-add over a 2W-bit product.
  - op=00 returns product[W-1:0].
  - op=01 returns product[2W-1:W].
  - div0=0 for MUL ops.
- DIV/MOD uses restoring division with a W-bit quotient and a W-bit remainder. One quotient bit is produced per iteration, MSB first; the trial subtraction is W+1 bits wide.
  - op=10 returns the quotient.
  - op=11 returns the remainder.
- Divide by zero: no special path and the same latency. The restoring algorithm yields quotient = all ones and remainder = a. div0=1 for DIV/MOD with b==0, otherwise 0.
- All arithmetic is unsigned; there is no overflow flag. MUL high/low selects the product half; there is no truncation error.
- rst asserted during DONE: done/wrt drop immediately (async), so no register write occurs.

Test Plan:
- Reset: hold rst=1 with start=1 -> busy=0, done=0, wrt=0, result=0x00, rd_out=0. Release rst, then pulse start with op=00, a=13, b=11, rd_in=5 -> busy=1 for 8 cycles; done=wrt=1 for one cycle after edge 8; result=0x8F, rd_out=5, div0=0.
- MUL high half: a=200, b=200 with op=01 -> result=0x9C. Repeat with op=00 -> result=0x40.
- DIV/MOD: a=200, b=7 with op=10 -> result=0x1C. Same operands with op=11 -> result=0x04, div0=0.
- Divide by zero: a=0x5A, b=0 with op=10 -> result=0xFF, div0=1. With op=11 -> result=0x5A, div0=1. Latency is 8 cycles in both cases.
- Handshake boundaries:
  - start held high through RUN -> ignored.
  - start=1 in DONE -> a new op launches with no IDLE cycle; busy rises on the next cycle; the second done comes 9 cycles after the first.
  - Changing a/b during RUN does not alter the result.
- Reset mid-operation: assert rst at RUN iteration 4 -> all outputs go to 0 immediately and no done/wrt pulse occurs. After release, a new op completes correctly.
